// File: rtl/uart_fifo_ctrl_pkg.sv
// Shared definitions for the buffered UART control block: register map,
// STATUS/CTRL bit positions and TX FSM state encoding.
package uart_fifo_ctrl_pkg;

  localparam logic [1:0] UART_ADDR_STATUS = 2'd0;
  localparam logic [1:0] UART_ADDR_CTRL   = 2'd1;
  localparam logic [1:0] UART_ADDR_DATA   = 2'd2;

  localparam int unsigned StatRxNotEmpty  = 0;
  localparam int unsigned StatRxThresh    = 1;
  localparam int unsigned StatTxEmpty     = 2;
  localparam int unsigned StatTxFull      = 3;
  localparam int unsigned StatRxOverrun   = 4;
  localparam int unsigned StatTxOverflow  = 5;
  localparam int unsigned StatTxActive    = 6;
  localparam int unsigned StatRxBusy      = 7;
  localparam int unsigned StatRxCountLsb  = 8;
  localparam int unsigned StatTxCountLsb  = 16;

  localparam int unsigned CtrlIrqRxEn     = 0;
  localparam int unsigned CtrlIrqTxEn     = 1;
  localparam int unsigned CtrlRxThreshLsb = 8;
  localparam int unsigned CtrlTxFlush     = 16;
  localparam int unsigned CtrlRxFlush     = 17;

  typedef enum logic [1:0] {
    TxIdle  = 2'd0,
    TxStart = 2'd1,
    TxWait  = 2'd2
  } tx_state_e;

  // A programmed threshold of zero behaves as one.
  function automatic logic [7:0] eff_thresh(input logic [7:0] thresh);
    return (thresh == 8'd0) ? 8'd1 : thresh;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with synchronous flush; pointers wrap modulo the depth and
// a separate occupancy count distinguishes full from empty.
module uart_sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      din_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [WIDTH-1:0]      dout_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Bus-facing UART controller with TX/RX FIFOs, RX threshold interrupt, sticky
// error flags and an FSM that drains the TX FIFO into uart_tx.
module uart_fifo_ctrl
  import uart_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2    = 4,
  parameter int unsigned RX_THRESH_RST = 1
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic [29:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy_,
  output logic        irq_rx,
  output logic        irq_tx,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        tx_end,
  input  logic        rx_busy,
  input  logic        rx_end,
  input  logic [7:0]  rx_data
);

  localparam int unsigned CntW = DEPTH_LOG2 + 1;

  tx_state_e   state_q, state_d;
  logic [31:0] rd_data_q, rd_data_d, rd_mux;
  logic        rdy_q;
  logic        irq_rx_q, irq_rx_d, irq_tx_q, irq_tx_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        irq_rx_en_q, irq_rx_en_d, irq_tx_en_q, irq_tx_en_d;
  logic [7:0]  rx_thresh_q, rx_thresh_d;
  logic        rx_overrun_q, rx_overrun_d, tx_overflow_q, tx_overflow_d;

  logic            access, rd_acc, wr_acc;
  logic [1:0]      reg_addr;
  logic            rx_push, rx_pop, rx_flush, rx_empty, rx_full;
  logic            tx_push, tx_pop, tx_flush, tx_empty, tx_full, tx_push_req;
  logic [7:0]      rx_dout, tx_dout, rx_count8, tx_count8;
  logic [CntW-1:0] rx_count, tx_count;
  logic            rx_ge, tx_active;
  logic            unused_bits;

  assign access      = ~cs_ & ~as_;
  assign rd_acc      = access & rw;
  assign wr_acc      = access & ~rw;
  assign reg_addr    = addr[1:0];
  assign unused_bits = ^{addr[29:2], wr_data[31:18]};
  assign rx_count8   = 8'(rx_count);
  assign tx_count8   = 8'(tx_count);
  assign rx_ge       = (rx_count8 >= eff_thresh(rx_thresh_q));

  always_comb begin
    rx_pop      = rd_acc && (reg_addr == UART_ADDR_DATA) && !rx_empty;
    rx_flush    = wr_acc && (reg_addr == UART_ADDR_CTRL) && wr_data[CtrlRxFlush];
    tx_flush    = wr_acc && (reg_addr == UART_ADDR_CTRL) && wr_data[CtrlTxFlush];
    tx_push_req = wr_acc && (reg_addr == UART_ADDR_DATA);
    tx_push     = tx_push_req && !tx_full;
    rx_push     = rx_end && !rx_flush && (!rx_full || rx_pop);
  end

  uart_sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rx_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_),
    .push_i  (rx_push),
    .din_i   (rx_data),
    .pop_i   (rx_pop),
    .flush_i (rx_flush),
    .dout_o  (rx_dout),
    .count_o (rx_count),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  uart_sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_tx_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_),
    .push_i  (tx_push),
    .din_i   (wr_data[7:0]),
    .pop_i   (tx_pop),
    .flush_i (tx_flush),
    .dout_o  (tx_dout),
    .count_o (tx_count),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  always_comb begin
    irq_rx_en_d   = irq_rx_en_q;
    irq_tx_en_d   = irq_tx_en_q;
    rx_thresh_d   = rx_thresh_q;
    rx_overrun_d  = rx_overrun_q;
    tx_overflow_d = tx_overflow_q;
    if (wr_acc && reg_addr == UART_ADDR_CTRL) begin
      irq_rx_en_d = wr_data[CtrlIrqRxEn];
      irq_tx_en_d = wr_data[CtrlIrqTxEn];
      rx_thresh_d = wr_data[CtrlRxThreshLsb +: 8];
    end
    if (wr_acc && reg_addr == UART_ADDR_STATUS) begin
      if (wr_data[StatRxOverrun])  rx_overrun_d  = 1'b0;
      if (wr_data[StatTxOverflow]) tx_overflow_d = 1'b0;
    end
    // Set events follow the clears so a coincident event wins over W1C.
    if (rx_end && !rx_flush && rx_full && !rx_pop) rx_overrun_d = 1'b1;
    if (tx_push_req && tx_full) tx_overflow_d = 1'b1;
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      UART_ADDR_STATUS: begin
        rd_mux[StatRxNotEmpty]          = ~rx_empty;
        rd_mux[StatRxThresh]            = rx_ge;
        rd_mux[StatTxEmpty]             = tx_empty;
        rd_mux[StatTxFull]              = tx_full;
        rd_mux[StatRxOverrun]           = rx_overrun_q;
        rd_mux[StatTxOverflow]          = tx_overflow_q;
        rd_mux[StatTxActive]            = tx_active;
        rd_mux[StatRxBusy]              = rx_busy;
        rd_mux[StatRxCountLsb +: 8]     = rx_count8;
        rd_mux[StatTxCountLsb +: 8]     = tx_count8;
      end
      UART_ADDR_CTRL: begin
        rd_mux[CtrlIrqRxEn]             = irq_rx_en_q;
        rd_mux[CtrlIrqTxEn]             = irq_tx_en_q;
        rd_mux[CtrlRxThreshLsb +: 8]    = rx_thresh_q;
      end
      UART_ADDR_DATA: begin
        if (!rx_empty) rd_mux[8:0] = {1'b1, rx_dout};
      end
      default: rd_mux = '0;
    endcase
    rd_data_d = rd_acc ? rd_mux : 32'h0;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state_q <= TxIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      TxIdle: begin
        if (!tx_empty && !tx_busy) begin
          state_d   = TxStart;
          tx_data_d = tx_dout;
        end
      end
      TxStart: state_d = TxWait;
      TxWait:  if (tx_end) state_d = TxIdle;
      default: state_d = TxIdle;
    endcase
  end

  always_comb begin
    tx_start  = (state_q == TxStart);
    tx_pop    = tx_start && !tx_empty;
    tx_active = (state_q != TxIdle);
  end

  assign irq_rx_d = irq_rx_en_q & rx_ge;
  assign irq_tx_d = irq_tx_en_q & tx_empty & (state_q == TxIdle);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rd_data_q     <= '0;
      rdy_q         <= 1'b1;
      irq_rx_q      <= 1'b0;
      irq_tx_q      <= 1'b0;
      tx_data_q     <= '0;
      irq_rx_en_q   <= 1'b0;
      irq_tx_en_q   <= 1'b0;
      rx_thresh_q   <= 8'(RX_THRESH_RST);
      rx_overrun_q  <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      rd_data_q     <= rd_data_d;
      rdy_q         <= ~access;
      irq_rx_q      <= irq_rx_d;
      irq_tx_q      <= irq_tx_d;
      tx_data_q     <= tx_data_d;
      irq_rx_en_q   <= irq_rx_en_d;
      irq_tx_en_q   <= irq_tx_en_d;
      rx_thresh_q   <= rx_thresh_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_overflow_q <= tx_overflow_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rdy_    = rdy_q;
  assign irq_rx  = irq_rx_q;
  assign irq_tx  = irq_tx_q;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Scoreboard bench for uart_fifo_ctrl: bus accesses push expected read data,
// a monitor checks each rdy_ strobe, and a uart_tx model checks the TX stream.
module tb_uart_fifo_ctrl;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_ = 1'b1;
  logic        cs_ = 1'b1, as_ = 1'b1, rw = 1'b0;
  logic [29:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        rdy_, irq_rx, irq_tx, tx_start;
  logic [7:0]  tx_data;
  logic        hold_busy = 1'b1, eng_busy = 1'b0;
  logic        tx_busy;
  logic        tx_end = 1'b0, rx_busy = 1'b0, rx_end = 1'b0;
  logic [7:0]  rx_data = '0;

  assign tx_busy = hold_busy | eng_busy;

  uart_fifo_ctrl dut (
    .clk     (clk),
    .reset_  (reset_),
    .cs_     (cs_),
    .as_     (as_),
    .rw      (rw),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .rdy_    (rdy_),
    .irq_rx  (irq_rx),
    .irq_tx  (irq_tx),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .tx_end  (tx_end),
    .rx_busy (rx_busy),
    .rx_end  (rx_end),
    .rx_data (rx_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  int rst_gen = 0;
  bit chk_irq = 1'b1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  // Reference model: FIFO contents as queues plus flag/control state.
  logic [7:0] rxq[$], txq[$];
  bit         m_ovr, m_ovf, m_rxen, m_txen;
  logic [7:0] m_thr = 8'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit rx_ge();
    int eff;
    eff = (m_thr == 8'd0) ? 1 : int'(m_thr);
    return rxq.size() >= eff;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      2'd0: begin
        v[0]     = rxq.size() != 0;
        v[1]     = rx_ge();
        v[2]     = txq.size() == 0;
        v[3]     = txq.size() == DEPTH;
        v[4]     = m_ovr;
        v[5]     = m_ovf;
        v[7]     = rx_busy;
        v[15:8]  = 8'(rxq.size());
        v[23:16] = 8'(txq.size());
      end
      2'd1: v = {16'h0, m_thr, 6'h0, m_txen, m_rxen};
      2'd2: if (rxq.size() != 0) v = {23'h0, 1'b1, rxq[0]};
      default: v = '0;
    endcase
    return v;
  endfunction

  // One stimulus cycle: optional bus access and/or rx_end, then a gap cycle.
  task automatic step(input bit bus, input bit rd, input logic [1:0] a,
                      input logic [31:0] wd, input bit rxe, input logic [7:0] rb);
    bit   rfl;
    exp_t e;
    rfl = 1'b0;
    @(posedge clk); #1;
    if (chk_irq) begin
      check("irq_rx", {31'h0, irq_rx}, {31'h0, m_rxen && rx_ge()});
      check("irq_tx", {31'h0, irq_tx}, {31'h0, m_txen && txq.size() == 0});
    end
    cs_ = ~bus; as_ = ~bus; rw = rd; addr = {28'h0, a}; wr_data = wd;
    rx_end = rxe; rx_data = rb;
    if (bus) begin
      e.data = rd ? model_read(a) : 32'h0;
      e.due  = cyc + 1;
      sb.push_back(e);
      if (rd && a == 2'd2 && rxq.size() != 0) void'(rxq.pop_front());
      if (!rd) begin
        case (a)
          2'd0: begin
            if (wd[4]) m_ovr = 1'b0;
            if (wd[5]) m_ovf = 1'b0;
          end
          2'd1: begin
            m_rxen = wd[0]; m_txen = wd[1]; m_thr = wd[15:8];
            if (wd[16]) txq.delete();
            if (wd[17]) begin rxq.delete(); rfl = 1'b1; end
          end
          2'd2: if (txq.size() < DEPTH) txq.push_back(wd[7:0]); else m_ovf = 1'b1;
          default: ;
        endcase
      end
    end
    if (rxe && !rfl) begin
      if (rxq.size() < DEPTH) rxq.push_back(rb); else m_ovr = 1'b1;
    end
    @(posedge clk); #1;
    cs_ = 1'b1; as_ = 1'b1; rx_end = 1'b0; wr_data = '0;
  endtask

  task automatic rd_reg(input logic [1:0] a);
    step(1'b1, 1'b1, a, 32'h0, 1'b0, 8'h0);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d, 1'b0, 8'h0);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    step(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, b);
  endtask

  task automatic drain();
    int i;
    hold_busy = 1'b0;
    for (i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (txq.size() == 0 && !eng_busy) break;
    end
    if (i >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL tx_drain_timeout: %0d bytes still queued, required 0", txq.size());
    end
    repeat (3) @(posedge clk);
    hold_busy = 1'b1;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    rst_gen++;
    #1;
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_rdy_", {31'h0, rdy_}, 32'h1);
    check("rst_irq_rx", {31'h0, irq_rx}, 32'h0);
    check("rst_irq_tx", {31'h0, irq_tx}, 32'h0);
    check("rst_tx_start", {31'h0, tx_start}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    rxq.delete(); txq.delete(); sb.delete();
    m_ovr = 0; m_ovf = 0; m_rxen = 0; m_txen = 0; m_thr = 8'd1;
    repeat (3) @(posedge clk);
    #1 reset_ = 1'b1;
  endtask

  // Read-response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_) begin
        while (sb.size() != 0 && sb[0].due < cyc) begin
          n_cmp++; n_bad++;
          $display("FAIL rdy_missing: no rdy_ for access due cycle %0d, now %0d", sb[0].due, cyc);
          void'(sb.pop_front());
        end
        if (!rdy_) begin
          if (sb.size() == 0) check("rdy_unexpected", {31'h0, rdy_}, 32'h1);
          else begin
            e = sb.pop_front();
            check("rdy_cycle", cyc, e.due);
            check("rd_data", rd_data, e.data);
          end
        end else begin
          check("rd_data_idle", rd_data, 32'h0);
        end
      end
    end
  end

  // uart_tx model: checks byte order, holds busy and returns tx_end 10 cycles on.
  initial begin
    forever begin
      logic [7:0] exp_b;
      int         g;
      @(negedge clk);
      if (reset_ && tx_start) begin
        if (txq.size() == 0) check("tx_unexpected", {31'h0, tx_start}, 32'h0);
        else begin
          exp_b = txq.pop_front();
          g = rst_gen;
          check("tx_data", {24'h0, tx_data}, {24'h0, exp_b});
          eng_busy = 1'b1;
          repeat (10) @(posedge clk);
          #1;
          if (rst_gen == g) check("tx_data_hold", {24'h0, tx_data}, {24'h0, exp_b});
          tx_end = 1'b1;
          @(posedge clk); #1;
          tx_end = 1'b0;
          eng_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wd;
    int          op;
    bit          rxe;
    logic [7:0]  b;

    #2;
    do_reset();
    rd_reg(2'd0);

    // Basic transmit of three bytes, then irq_tx once idle.
    wr_reg(2'd1, 32'h0000_0102);
    chk_irq = 1'b0;
    hold_busy = 1'b0;
    wr_reg(2'd2, 32'h41);
    wr_reg(2'd2, 32'h42);
    wr_reg(2'd2, 32'h43);
    drain();
    chk_irq = 1'b1;
    rd_reg(2'd0);

    // RX overrun: 17 bytes into a 16-deep FIFO, then read everything back.
    for (int i = 0; i <= 16; i++) rx_byte(8'(i));
    rd_reg(2'd0);
    for (int i = 0; i <= 16; i++) rd_reg(2'd2);
    wr_reg(2'd0, 32'h30);
    rd_reg(2'd0);

    // Threshold interrupt with one-cycle registered latency.
    wr_reg(2'd1, 32'h0000_0401);
    for (int i = 0; i < 3; i++) rx_byte(8'h60 + 8'(i));
    rx_byte(8'h63);
    check("irq_rx_latency_lo", {31'h0, irq_rx}, 32'h0);
    @(posedge clk); #1;
    check("irq_rx_latency_hi", {31'h0, irq_rx}, 32'h1);
    rd_reg(2'd2);
    rd_reg(2'd0);

    // Full RX FIFO with a DATA read and rx_end together.
    wr_reg(2'd1, 32'h0002_0401);
    for (int i = 0; i < DEPTH; i++) rx_byte(8'h80 + 8'(i));
    step(1'b1, 1'b1, 2'd2, 32'h0, 1'b1, 8'hA5);
    rd_reg(2'd0);
    for (int i = 0; i < DEPTH; i++) rd_reg(2'd2);
    rd_reg(2'd1);

    // Randomised mix with the TX engine frozen.
    for (int k = 0; k < 400; k++) begin
      op  = $urandom_range(0, 9);
      rxe = ($urandom_range(0, 2) == 0);
      b   = 8'($urandom);
      rx_busy = 1'($urandom);
      case (op)
        0, 1: step(1'b1, 1'b1, 2'($urandom_range(0, 3)), 32'h0, rxe, b);
        2:    step(1'b1, 1'b1, 2'd2, 32'h0, rxe, b);
        3, 4: step(1'b1, 1'b0, 2'd2, $urandom, rxe, b);
        5:    step(1'b1, 1'b0, ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0, $urandom, rxe, b);
        6: begin
          wd = {14'h0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                8'($urandom_range(0, 20)), 6'h0, 2'($urandom)};
          step(1'b1, 1'b0, 2'd1, wd, rxe, b);
        end
        default: step(1'b0, 1'b0, 2'd0, 32'h0, rxe, b);
      endcase
    end
    rx_busy = 1'b0;
    chk_irq = 1'b0;
    drain();
    chk_irq = 1'b1;
    rd_reg(2'd0);

    // Reset while a byte is in flight and both FIFOs hold data.
    wr_reg(2'd1, 32'h0000_0103);
    for (int i = 0; i < 3; i++) rx_byte(8'h20 + 8'(i));
    for (int i = 0; i < 4; i++) wr_reg(2'd2, 32'h51 + i);
    chk_irq = 1'b0;
    hold_busy = 1'b0;
    for (int i = 0; i < 200 && !eng_busy; i++) @(posedge clk);
    check("tx_started", {31'h0, eng_busy}, 32'h1);
    repeat (4) @(posedge clk);
    #3;
    do_reset();
    for (int i = 0; i < 200 && eng_busy; i++) @(posedge clk);
    hold_busy = 1'b1;
    chk_irq = 1'b1;
    rd_reg(2'd0);
    rd_reg(2'd1);

    repeat (4) @(posedge clk);
    check("sb_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
